// File: rtl/ma_request_arbiter_pkg.sv
// Shared constants for the MA request arbiter: stage IDs, MA request width and MA_TYPE_2 codes.
package ma_request_arbiter_pkg;

  localparam int unsigned MA_REQ_W = 128;

  localparam logic [1:0] STAGE_HOST           = 2'b00;
  localparam logic [1:0] FIND_OR_INSERT       = 2'b01;
  localparam logic [1:0] STAGE_APPLY          = 2'b10;
  localparam logic [1:0] STAGE_REDUCE         = 2'b11;

  typedef enum logic [1:0] {
    MaFetch     = 2'b00,
    MaInsert    = 2'b01,
    MaWriteNext = 2'b10,
    MaReserved  = 2'b11
  } maType2E;

  // Requesters use this to derive req_expect_resp from their MA_TYPE_2 code.
  function automatic logic expectsResp(input maType2E maType);
    return (maType == MaFetch) || (maType == MaInsert);
  endfunction

endpackage

// File: rtl/ma_request_arbiter_rr_priority_pick.sv
// Round-robin pick: first eligible requester after the last-granted pointer wins (one-hot).
module ma_request_arbiter_rr_priority_pick
  import ma_request_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [1:0]         last,
  input  logic [NUM_REQ-1:0] eligible,
  output logic [NUM_REQ-1:0] grant
);

  int  idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      idx = (int'(last) + k) % int'(NUM_REQ);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ma_request_arbiter.sv
// Round-robin arbiter sharing the MA request stream, with a credit limit on in-flight requests.
// Optional per-requester grant counters when MA_ARB_STATS_EN is defined.
module ma_request_arbiter
  import ma_request_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_W          = MA_REQ_W,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_expect_resp,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         aso_request_data,
  output logic [1:0]                aso_request_channel,
  output logic                      aso_request_valid,
  input  logic                      aso_request_ready,
  input  logic                      asi_result_valid,
  output logic [3:0]                outstanding,
  output logic                      err_underflow
`ifdef MA_ARB_STATS_EN
  ,
  input  logic                      stats_clear,
  output logic [NUM_REQ*16-1:0]     grant_count
`endif
);

  localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

  logic               loadEn;
  logic               accepted;
  logic               inc;
  logic               dec;
  logic               creditAvail;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grantIdx;
  logic [1:0]         lastPtr;
  logic [DATA_W-1:0]  grantData;

  ma_request_arbiter_rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .last     (lastPtr),
    .eligible (eligible),
    .grant    (grant)
  );

  always_comb begin
    loadEn      = !aso_request_valid || aso_request_ready;
    creditAvail = outstanding < MaxOut;
    eligible    = req_valid & (~req_expect_resp | {NUM_REQ{creditAvail}});
    grantIdx    = '0;
    grantData   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        grantIdx  = 2'(i);
        grantData = req_data[i*DATA_W +: DATA_W];
      end
    end
    req_ready = grant & {NUM_REQ{loadEn}};
    accepted  = loadEn && (|grant);
    inc       = accepted && (|(grant & req_expect_resp));
    dec       = asi_result_valid;
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aso_request_valid   <= 1'b0;
      aso_request_data    <= '0;
      aso_request_channel <= '0;
      lastPtr             <= 2'(NUM_REQ - 1);
    end else if (loadEn) begin
      if (accepted) begin
        aso_request_valid   <= 1'b1;
        aso_request_data    <= grantData;
        aso_request_channel <= grantIdx;
        lastPtr             <= grantIdx;
      end else begin
        aso_request_valid   <= 1'b0;
      end
    end
  end

  // Credits: eligibility guarantees inc never pushes past MAX_OUTSTANDING.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else if (inc && !dec) begin
      outstanding <= outstanding + 4'd1;
    end else if (dec && !inc) begin
      if (outstanding != 4'd0) begin
        outstanding <= outstanding - 4'd1;
      end else begin
        err_underflow <= 1'b1;
      end
    end
  end

`ifdef MA_ARB_STATS_EN
  logic [15:0] grantCnt [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REQ); i++) grantCnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (stats_clear) begin
          grantCnt[i] <= '0;
        end else if (accepted && grant[i]) begin
          grantCnt[i] <= grantCnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) grant_count[i*16 +: 16] = grantCnt[i];
  end
`endif

endmodule

// File: tb/tb_ma_request_arbiter.sv
// Self-checking bench for ma_request_arbiter: directed steps plus random traffic vs a reference model.
module tb_ma_request_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 128;
  localparam int MAXO = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NR*DW-1:0]   reqData = '0;
  logic [NR-1:0]      reqValid = '0;
  logic [NR-1:0]      reqExpect = '0;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      aso_request_data;
  logic [1:0]         aso_request_channel;
  logic               aso_request_valid;
  logic               maReady = 1'b1;
  logic               resultValid = 1'b0;
  logic [3:0]         outstanding;
  logic               err_underflow;
  logic               statsClear = 1'b0;
`ifdef MA_ARB_STATS_EN
  logic [NR*16-1:0]   grant_count;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state
  int          mOut, mLast, mChan;
  logic        mValid, mErr;
  logic [DW-1:0] mData;
  int          mCnt [NR];

  always #5 clk = ~clk;

  ma_request_arbiter #(
    .NUM_REQ         (NR),
    .DATA_W          (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_data            (reqData),
    .req_valid           (reqValid),
    .req_expect_resp     (reqExpect),
    .req_ready           (req_ready),
    .aso_request_data    (aso_request_data),
    .aso_request_channel (aso_request_channel),
    .aso_request_valid   (aso_request_valid),
    .aso_request_ready   (maReady),
    .asi_result_valid    (resultValid),
    .outstanding         (outstanding),
    .err_underflow       (err_underflow)
`ifdef MA_ARB_STATS_EN
    ,
    .stats_clear         (statsClear),
    .grant_count         (grant_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOut = 0; mLast = NR - 1; mChan = 0; mValid = 1'b0; mErr = 1'b0; mData = '0;
    for (int i = 0; i < NR; i++) mCnt[i] = 0;
  endtask

  task automatic checkOutputs(input string tag);
    check({tag, " valid"}, 128'(aso_request_valid), 128'(mValid));
    check({tag, " data"}, aso_request_data, mData);
    check({tag, " chan"}, 128'(aso_request_channel), 128'(mChan));
    check({tag, " outstanding"}, 128'(outstanding), 128'(mOut));
    check({tag, " err"}, 128'(err_underflow), 128'(mErr));
  endtask

  task automatic checkStats(input string tag);
`ifdef MA_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      check({tag, " grant_count"}, 128'(grant_count[i*16 +: 16]), 128'(mCnt[i] % 65536));
`else
    check({tag, " no-stats slot"}, 128'(aso_request_channel), 128'(mChan));
`endif
  endtask

  // One clock: check predicted req_ready, advance model at the edge, check registered outputs.
  task automatic cycle(input string tag);
    int   g;
    int   idx;
    logic le;
    logic [NR-1:0] expReady;
    #1;
    le = !mValid || maReady;
    g = -1;
    if (le) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (mLast + k) % NR;
        if (g < 0 && reqValid[idx] && (!reqExpect[idx] || mOut < MAXO)) g = idx;
      end
    end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    check({tag, " req_ready"}, 128'(req_ready), 128'(expReady));
    @(posedge clk);
    if (le) begin
      if (g >= 0) begin
        mValid = 1'b1;
        mData  = reqData[g*DW +: DW];
        mChan  = g;
        mLast  = g;
        mCnt[g] = mCnt[g] + 1;
      end else begin
        mValid = 1'b0;
      end
    end
    if (statsClear) for (int i = 0; i < NR; i++) mCnt[i] = 0;
    if ((g >= 0 && reqExpect[g]) && !resultValid) mOut++;
    else if (!(g >= 0 && reqExpect[g]) && resultValid) begin
      if (mOut > 0) mOut--;
      else mErr = 1'b1;
    end
    #1;
    checkOutputs(tag);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutputs("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    modelReset();
    doReset();
    checkStats("reset stats");

    // Single requester 1 fetch
    reqData = '0;
    reqData[1*DW +: DW] = 128'hA5;
    reqValid = 4'b0010; reqExpect = 4'b0010; maReady = 1'b1;
    cycle("t1");
    check("t1 chan", 128'(aso_request_channel), 128'd1);
    check("t1 data", aso_request_data, 128'hA5);
    check("t1 out", 128'(outstanding), 128'd1);
    reqValid = '0;
    cycle("t1 idle");

    // All requesters, no responses: strict rotation without bubbles
    doReset();
    for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = 128'(32'hD000 + i);
    reqValid = 4'b1111; reqExpect = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      cycle("t2");
      check("t2 order", 128'(aso_request_channel), 128'(k % NR));
      check("t2 valid", 128'(aso_request_valid), 128'd1);
    end

    // Backpressure holds the slot
    maReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("t3");
      check("t3 hold chan", 128'(aso_request_channel), 128'd3);
      check("t3 hold data", aso_request_data, 128'hD003);
    end
    maReady = 1'b1;
    cycle("t3 release");
    check("t3 next", 128'(aso_request_channel), 128'd0);

    // Credit exhaustion does not block non-expecting requesters
    doReset();
    reqValid = 4'b0001; reqExpect = 4'b0001;
    for (int k = 0; k < 4; k++) cycle("t4 fill");
    check("t4 full", 128'(outstanding), 128'd4);
    reqValid = 4'b0101;
    cycle("t4 bypass");
    check("t4 req2 granted", 128'(aso_request_channel), 128'd2);
    reqValid = 4'b0001; resultValid = 1'b1;
    cycle("t4 result");
    resultValid = 1'b0;
    check("t4 after result", 128'(outstanding), 128'd3);
    cycle("t4 regrant");
    check("t4 req0 granted", 128'(aso_request_channel), 128'd0);
    check("t4 refull", 128'(outstanding), 128'd4);

    // Simultaneous inc/dec, then underflow
    doReset();
    reqValid = 4'b0001; reqExpect = 4'b0001;
    cycle("t5 a"); cycle("t5 b");
    resultValid = 1'b1;
    cycle("t5 both");
    check("t5 stays 2", 128'(outstanding), 128'd2);
    reqValid = '0;
    cycle("t5 dec1"); cycle("t5 dec2");
    check("t5 zero no err", 128'(err_underflow), 128'd0);
    cycle("t5 underflow");
    resultValid = 1'b0;
    check("t5 err set", 128'(err_underflow), 128'd1);
    check("t5 still zero", 128'(outstanding), 128'd0);
    for (int k = 0; k < 3; k++) cycle("t5 sticky");
    check("t5 err sticky", 128'(err_underflow), 128'd1);

    // Random traffic against the model
    doReset();
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < NR * DW / 32; w++) reqData[w*32 +: 32] = $urandom;
      reqValid    = 4'($urandom);
      reqExpect   = 4'($urandom);
      maReady     = ($urandom_range(0, 3) != 0);
      resultValid = (mOut > 0) && ($urandom_range(0, 2) == 0);
      statsClear  = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    resultValid = 1'b0; statsClear = 1'b0;
    checkStats("rand stats");
    statsClear = 1'b1;
    cycle("clear");
    statsClear = 1'b0;
    checkStats("cleared stats");

    // Asynchronous reset during backpressure
    reqValid = 4'b1111; reqExpect = 4'b0000; maReady = 1'b0;
    cycle("t7 fill");
    cycle("t7 stall");
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    check("t7 async valid", 128'(aso_request_valid), 128'd0);
    check("t7 async data", aso_request_data, 128'd0);
    check("t7 async chan", 128'(aso_request_channel), 128'd0);
    check("t7 async out", 128'(outstanding), 128'd0);
    checkStats("t7 stats");
    @(negedge clk);
    reset = 1'b0;
    maReady = 1'b1;
    reqData[1*DW +: DW] = 128'h77;
    reqValid = 4'b0010;
    cycle("t7 single");
    reqValid = 4'b1111;
    cycle("t7 restart");
    check("t7 after req1 next is 2", 128'(aso_request_channel), 128'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
